// File: rtl/leve1_pkg.sv
// Shared types and constants for the RV64M divide sequencer.
//   div_op_t    : funct3[1:0] encoding of the divide/remainder ops
//   div_state_t : sequencer controller states
//   DIV_ITER64/DIV_ITER32 : restoring-step counts for full-width and W ops
`ifndef XLEN
`define XLEN 64
`endif

package leve1_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } div_state_t;

  localparam int DIV_ITER64 = 64;
  localparam int DIV_ITER32 = 32;

  // funct3[0]=0 marks the signed flavours (DIV, REM).
  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

  // funct3[1]=1 selects the remainder result.
  function automatic logic op_is_rem(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/leve1_div_step.sv
// One combinational restoring-divide iteration.
//   r_i [XLEN:0]   partial remainder
//   q_i [XLEN-1:0] dividend/quotient shift register (msb feeds the remainder)
//   d_i [XLEN-1:0] divisor magnitude
//   r_o, q_o       remainder and quotient after this step
module leve1_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   r_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN:0]   r_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] r_sh;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    r_sh = {r_i[XLEN-1:0], q_i[XLEN-1]};
    diff = r_sh - {1'b0, d_i};
    // The remainder never exceeds the divisor between steps, so r_i[XLEN]
    // stays clear; if it were set the shifted value would certainly exceed d.
    ge   = r_i[XLEN] | (r_sh >= {1'b0, d_i});
    r_o  = ge ? diff : r_sh;
    q_o  = {q_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/leve1_div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer (DIV/DIVU/REM/REMU + W forms).
// EX hands over one op, stalls on BUSY, and collects the result.
//   CLK, RSTn              clock, async active-low reset
//   REQ_VALID/REQ_READY    request handshake; REQ_OP funct3[1:0], REQ_W W-form
//   REQ_A, REQ_B           dividend / divisor
//   FLUSH                  abort whatever is in flight, return to IDLE
//   RSP_VALID/RSP_READY    response handshake; RSP_DATA result
//   BUSY                   high whenever the sequencer is not IDLE
module leve1_div_seq
  import leve1_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [1:0]      REQ_OP,
  input  logic            REQ_W,
  input  logic [XLEN-1:0] REQ_A,
  input  logic [XLEN-1:0] REQ_B,
  input  logic            FLUSH,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [XLEN-1:0] RSP_DATA,
  output logic            BUSY
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-32){1'b1}}, 32'h8000_0000};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  div_state_t      state_q, state_d;
  div_op_t         op_q, op_d;
  logic            w_q, w_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] d_q, d_d;
  logic [XLEN-1:0] res_q, res_d;

  // Request decode
  div_op_t         req_op;
  logic            sgn, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, q_init;

  // Step and fix-up results
  logic [XLEN:0]   step_r;
  logic [XLEN-1:0] step_q;
  logic [XLEN-1:0] q_fin, r_fin, res_sel, res_fix;

  leve1_div_step #(.XLEN(XLEN)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  always_comb begin
    req_op = div_op_t'(REQ_OP);
    sgn    = op_is_signed(req_op);
    a_ext  = REQ_W ? (sgn ? sext32(REQ_A[31:0]) : zext32(REQ_A[31:0])) : REQ_A;
    b_ext  = REQ_W ? (sgn ? sext32(REQ_B[31:0]) : zext32(REQ_B[31:0])) : REQ_B;
    a_neg  = sgn & a_ext[XLEN-1];
    b_neg  = sgn & b_ext[XLEN-1];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf    = sgn && (a_ext == (REQ_W ? MIN_W : MIN_X)) && (b_ext == '1);
    // W magnitudes fit in 32 bits; park them at the top of q so that
    // 32 shifts bring the quotient into q[31:0].
    q_init = REQ_W ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
  end

  always_comb begin
    q_fin   = neg_q_q ? -q_q : q_q;
    r_fin   = neg_r_q ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
    res_sel = op_is_rem(op_q) ? r_fin : q_fin;
    res_fix = w_q ? sext32(res_sel[31:0]) : res_sel;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    w_d     = w_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (REQ_VALID && !FLUSH) begin
          op_d    = req_op;
          w_d     = REQ_W;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          cnt_d   = REQ_W ? CW'(DIV_ITER32) : CW'(XLEN);
          r_d     = '0;
          q_d     = q_init;
          d_d     = b_mag;
          if (b_zero) begin
            res_d   = op_is_rem(req_op) ? (REQ_W ? sext32(REQ_A[31:0]) : REQ_A) : '1;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = op_is_rem(req_op) ? '0 : a_ext;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        res_d   = res_fix;
        state_d = DONE;
      end
      DONE: begin
        if (RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (FLUSH) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_q    <= DIV;
      w_q     <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
    end else begin
      op_q    <= op_d;
      w_q     <= w_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      res_q   <= res_d;
    end
  end

  assign REQ_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == DONE);
  assign RSP_DATA  = res_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_leve1_div_seq.sv
// Self-checking bench for leve1_div_seq: directed corner cases plus
// randomized ops compared against a plain-arithmetic divide model.
module tb_leve1_div_seq;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [1:0]  REQ_OP = 2'b00;
  logic        REQ_W = 1'b0;
  logic [63:0] REQ_A = '0;
  logic [63:0] REQ_B = '0;
  logic        FLUSH = 1'b0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [63:0] RSP_DATA;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_data = '0;

  leve1_div_seq #(.XLEN(64)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP), .REQ_W(REQ_W),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .FLUSH(FLUSH),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // RISC-V M semantics straight from the ISA rules, using native division.
  function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic        sgn, rem;
    int          sa, sb;
    int unsigned ua, ub;
    longint      la, lb;
    logic [31:0] r32;
    logic [63:0] r64;
    sgn = !op[0];
    rem = op[1];
    if (w) begin
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      if (b[31:0] == 32'h0)                                    r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (sgn && a[31:0] == 32'h8000_0000 && sb == -1)    r32 = rem ? 32'h0 : a[31:0];
      else if (sgn)                                            r32 = rem ? sa % sb : sa / sb;
      else                                                     r32 = rem ? ua % ub : ua / ub;
      return {{32{r32[31]}}, r32};
    end
    la = a; lb = b;
    if (b == 64'h0)                                            r64 = rem ? a : '1;
    else if (sgn && a == 64'h8000_0000_0000_0000 && lb == -1)  r64 = rem ? 64'h0 : a;
    else if (sgn)                                              r64 = rem ? la % lb : la / lb;
    else                                                       r64 = rem ? a % b : a / b;
    return r64;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic z, o;
    z = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    o = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (z || o) ? 1 : (w ? 34 : 66);
  endfunction

  // Whenever a result is presented it must match the model, and BUSY must
  // always be the complement of REQ_READY.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (RSP_VALID) chk("rsp_data_vs_model", RSP_DATA, exp_data);
      chk("busy_vs_ready", {63'h0, BUSY}, {63'h0, !REQ_READY});
    end
  end

  task automatic run_op(input string nm, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input int hold, input int flush_at);
    int n, lat;
    logic saw_valid;
    n = 0;
    while (!REQ_READY && n < 10) begin @(posedge CLK); #1; n++; end
    chk({nm, "_req_ready"}, {63'h0, REQ_READY}, 64'h1);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_W = w; REQ_A = a; REQ_B = b;
    exp_data = exp;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    REQ_A = {$urandom, $urandom};
    REQ_B = {$urandom, $urandom};
    lat = 1;
    if (flush_at > 0) begin
      repeat (flush_at - 1) begin @(posedge CLK); #1; end
      FLUSH = 1'b1;
      @(posedge CLK); #1;
      FLUSH = 1'b0;
      chk({nm, "_flush_valid"}, {63'h0, RSP_VALID}, 64'h0);
      chk({nm, "_flush_ready"}, {63'h0, REQ_READY}, 64'h1);
      saw_valid = 1'b0;
      repeat (70) begin @(posedge CLK); #1; saw_valid |= RSP_VALID; end
      chk({nm, "_flush_no_rsp"}, {63'h0, saw_valid}, 64'h0);
      return;
    end
    while (!RSP_VALID && lat < 200) begin @(posedge CLK); #1; lat++; end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat(op, w, a, b)));
    chk({nm, "_data"}, RSP_DATA, exp);
    repeat (hold) begin
      @(posedge CLK); #1;
      chk({nm, "_hold_data"}, RSP_DATA, exp);
      chk({nm, "_hold_busy"}, {62'h0, RSP_VALID, BUSY}, 64'h3);
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    chk({nm, "_retired"}, {62'h0, RSP_VALID, REQ_READY}, 64'h1);
  endtask

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [1:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;

    #12;
    chk("reset_outputs", {RSP_DATA[61:0], REQ_READY, RSP_VALID}, 64'h2);
    chk("reset_busy", {63'h0, BUSY}, 64'h0);
    RSTn = 1'b1;
    @(posedge CLK); #1;

    // Pin the model to hand-computed values.
    chk("model_div_100_7", model(2'b00, 1'b0, 64'd100, 64'd7), 64'd14);
    chk("model_rem_m7_2", model(2'b10, 1'b0, -64'sd7, 64'd2), ONES);
    chk("model_divw_ovf", model(2'b00, 1'b1, 64'h8000_0000, ONES), 64'hFFFF_FFFF_8000_0000);
    chk("model_divuw_upper", model(2'b01, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1_0000_000A), 64'hA);

    run_op("div_100_7",   2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 0, 0);
    run_op("rem_100_7",   2'b10, 1'b0, 64'd100, 64'd7, 64'd2, 0, 0);
    run_op("rem_m7_2",    2'b10, 1'b0, -64'sd7, 64'd2, ONES, 0, 0);
    run_op("div_m7_2",    2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
    run_op("divu_ones_2", 2'b01, 1'b0, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    run_op("divu_5_0",    2'b01, 1'b0, 64'd5, 64'd0, ONES, 0, 0);
    run_op("remu_5_0",    2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 0, 0);
    run_op("div_ovf",     2'b00, 1'b0, MIN64, ONES, MIN64, 0, 0);
    run_op("rem_ovf",     2'b10, 1'b0, MIN64, ONES, 64'd0, 0, 0);
    run_op("divw_ovf",    2'b00, 1'b1, 64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 0, 0);
    run_op("backpress",   2'b00, 1'b0, 64'd1000, 64'd33, 64'd30, 5, 0);
    run_op("flush_calc",  2'b00, 1'b0, 64'd1000, 64'd33, 64'd30, 0, 10);
    run_op("after_flush", 2'b10, 1'b0, 64'd1000, 64'd33, 64'd10, 0, 0);
    run_op("divuw_upper", 2'b01, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1_0000_000A, 64'hA, 0, 0);

    // Flush wins over a simultaneous request.
    REQ_VALID = 1'b1; FLUSH = 1'b1; REQ_OP = 2'b01; REQ_W = 1'b0; REQ_A = 64'd9; REQ_B = 64'd3;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; FLUSH = 1'b0;
    chk("flush_vs_req", {62'h0, BUSY, REQ_READY}, 64'h1);

    // Flush together with RSP_READY in DONE returns to IDLE.
    REQ_VALID = 1'b1; REQ_OP = 2'b01; REQ_A = 64'd5; REQ_B = 64'd0; exp_data = ONES;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("done_before_flush", {63'h0, RSP_VALID}, 64'h1);
    FLUSH = 1'b1; RSP_READY = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0; RSP_READY = 1'b0;
    chk("flush_in_done", {62'h0, RSP_VALID, REQ_READY}, 64'h1);

    // Asynchronous reset in the middle of a calculation.
    REQ_VALID = 1'b1; REQ_OP = 2'b00; REQ_W = 1'b0; REQ_A = 64'd12345; REQ_B = 64'd7;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    repeat (20) @(posedge CLK);
    #3 RSTn = 1'b0;
    #1;
    chk("async_reset_mid", {RSP_DATA[61:0], REQ_READY, RSP_VALID}, 64'h2);
    chk("async_reset_busy", {63'h0, BUSY}, 64'h0);
    @(posedge CLK); #2 RSTn = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom} >> $urandom_range(0, 63);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin rb = ONES; ra = rw ? {ra[63:32], 32'h8000_0000} : MIN64; end
        2: rb = ONES;
        3: ra = ra >> $urandom_range(0, 63);
        default: ;
      endcase
      run_op("random", rop, rw, ra, rb, model(rop, rw, ra, rb), $urandom_range(0, 3), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
